// File: rtl/cache_mem_responder_pkg.sv
// Shared constants and types for the cache memory-side responder.
// Access-size encodings match the cache's request types.
package cache_mem_responder_pkg;

    localparam logic [2:0] ACCESS_SZ_BYTE = 3'b000;
    localparam logic [2:0] ACCESS_SZ_HALF = 3'b001;
    localparam logic [2:0] ACCESS_SZ_WORD = 3'b010;
    localparam logic [2:0] ACCESS_SZ_LINE = 3'b100;

    localparam int LOG_W_DEF = 2;
    localparam int W_DEF     = 1 << LOG_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_GAP   = 2'd3
    } rsp_state_e;

    function automatic logic is_line_access(input logic [2:0] access_type);
        return access_type == ACCESS_SZ_LINE;
    endfunction

endpackage

// File: rtl/cache_mem_responder_mem_line_ram.sv
// Line-organised RAM: one byte-enabled write port, one combinational row read.
// Each byte lane is its own array so partial-word writes stay single-driver.
module mem_line_ram #(
    parameter int ROW_AW = 10,
    parameter int BYTES  = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ROW_AW-1:0]    waddr,
    input  logic [BYTES-1:0]     wbe,
    input  logic [8*BYTES-1:0]   wdata,
    input  logic [ROW_AW-1:0]    raddr,
    output logic [8*BYTES-1:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [2**ROW_AW];

            always_ff @(posedge clk) begin
                if (we && wbe[gi]) begin
                    lane_mem[waddr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory model below the cache: serves word/line reads as ret_* beats
// and commits line/word writes into a local line RAM.
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int LOG_W   = LOG_W_DEF,
    parameter int MEM_AW  = 12,
    parameter int RET_GAP = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_req,
    input  logic [2:0]             rd_type,
    input  logic [31:0]            rd_addr,
    output logic                   rd_rdy,
    output logic                   ret_valid,
    output logic                   ret_last,
    output logic [31:0]            ret_data,
    input  logic                   wr_req,
    input  logic [2:0]             wr_type,
    input  logic [31:0]            wr_addr,
    input  logic [3:0]             wr_wstrb,
    input  logic [2:0]             wr_size,
    input  logic [32*(1<<LOG_W)-1:0] wr_data,
    output logic                   wr_rdy
);

    localparam int W      = 1 << LOG_W;
    localparam int ROW_AW = MEM_AW - LOG_W;
    localparam int LINE_W = 32 * W;
    localparam logic [LOG_W-1:0] CNT_LAST = LOG_W'(W - 1);
    localparam logic [2:0]       GAP_LAST = 3'(RET_GAP - 1);

    rsp_state_e        state_reg, state_next;
    logic [ROW_AW-1:0] row_reg, row_next;
    logic              line_reg, line_next;
    logic [LOG_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        gap_reg, gap_next;
    logic              ret_valid_reg, ret_valid_next;
    logic              ret_last_reg, ret_last_next;
    logic [31:0]       ret_data_reg, ret_data_next;

    logic              idle, wr_acc, rd_acc, rd_line, wr_line, burst_done;
    logic [ROW_AW-1:0] rd_row, wr_row, ram_raddr;
    logic [LOG_W-1:0]  rd_word, wr_word, cnt_inc, beat_sel;
    logic [LINE_W-1:0] ram_rdata, ram_wdata;
    logic [4*W-1:0]    ram_wbe;
    logic [31:0]       line_words [W];
    logic [31:0]       beat_word;

    // Address bits above the memory size and below word granularity are don't-care.
    logic unused_bits;
    assign unused_bits = ^{wr_size, rd_addr[31:MEM_AW+2], rd_addr[1:0],
                           wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    assign idle   = (state_reg == ST_IDLE);
    assign wr_rdy = idle && !reset;
    // A pending write takes the slot so a dirty writeback lands before its refill.
    assign rd_rdy = wr_rdy && !wr_req;
    assign wr_acc = wr_req && wr_rdy;
    assign rd_acc = rd_req && rd_rdy;

    assign rd_line = is_line_access(rd_type);
    assign wr_line = is_line_access(wr_type);
    assign rd_row  = rd_addr[MEM_AW+1:LOG_W+2];
    assign rd_word = rd_addr[LOG_W+1:2];
    assign wr_row  = wr_addr[MEM_AW+1:LOG_W+2];
    assign wr_word = wr_addr[LOG_W+1:2];

    assign ram_wbe   = wr_line ? '1 : ((4*W)'(wr_wstrb) << {wr_word, 2'b00});
    assign ram_wdata = wr_line ? wr_data : {W{wr_data[31:0]}};

    // The first beat is fetched straight from the request; later beats from the latched row.
    assign ram_raddr = idle ? rd_row : row_reg;
    assign cnt_inc   = cnt_reg + LOG_W'(1);
    assign beat_sel  = idle ? (rd_line ? '0 : rd_word) : cnt_inc;

    mem_line_ram #(
        .ROW_AW (ROW_AW),
        .BYTES  (4 * W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_row),
        .wbe   (ram_wbe),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_word
            assign line_words[gi] = ram_rdata[32*gi +: 32];
        end
    endgenerate

    assign beat_word  = line_words[beat_sel];
    assign burst_done = !line_reg || (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        line_next      = line_reg;
        cnt_next       = cnt_reg;
        gap_next       = gap_reg;
        ret_valid_next = 1'b0;
        ret_last_next  = 1'b0;
        ret_data_next  = ret_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (wr_acc) begin
                    state_next = ST_WRITE;
                end else if (rd_acc) begin
                    state_next     = ST_READ;
                    row_next       = rd_row;
                    line_next      = rd_line;
                    cnt_next       = '0;
                    ret_valid_next = 1'b1;
                    ret_data_next  = beat_word;
                    ret_last_next  = !rd_line || (W == 1);
                end
            end
            ST_WRITE: begin
                state_next = ST_IDLE;
            end
            ST_READ: begin
                if (burst_done) begin
                    state_next = ST_IDLE;
                end else if (RET_GAP == 0) begin
                    cnt_next       = cnt_inc;
                    ret_valid_next = 1'b1;
                    ret_data_next  = beat_word;
                    ret_last_next  = (cnt_inc == CNT_LAST);
                end else begin
                    state_next = ST_GAP;
                    gap_next   = '0;
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next     = ST_READ;
                    cnt_next       = cnt_inc;
                    ret_valid_next = 1'b1;
                    ret_data_next  = beat_word;
                    ret_last_next  = (cnt_inc == CNT_LAST);
                end else begin
                    gap_next = gap_reg + 3'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            row_reg       <= '0;
            line_reg      <= 1'b0;
            cnt_reg       <= '0;
            gap_reg       <= '0;
            ret_valid_reg <= 1'b0;
            ret_last_reg  <= 1'b0;
            ret_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            line_reg      <= line_next;
            cnt_reg       <= cnt_next;
            gap_reg       <= gap_next;
            ret_valid_reg <= ret_valid_next;
            ret_last_reg  <= ret_last_next;
            ret_data_reg  <= ret_data_next;
        end
    end

    assign ret_valid = ret_valid_reg;
    assign ret_last  = ret_last_reg;
    assign ret_data  = ret_data_reg;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: one zero-gap instance and one RET_GAP=2 instance.
module tb_cache_mem_responder;
    import cache_mem_responder_pkg::*;

    logic         clk = 1'b0;
    int           checks = 0;
    int           errors = 0;

    logic         reset, rd_req, wr_req;
    logic [2:0]   rd_type, wr_type, wr_size;
    logic [31:0]  rd_addr, wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         rd_rdy, wr_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;

    logic         g_reset, g_rd_req, g_wr_req;
    logic [2:0]   g_rd_type, g_wr_type, g_wr_size;
    logic [31:0]  g_rd_addr, g_wr_addr;
    logic [3:0]   g_wr_wstrb;
    logic [127:0] g_wr_data;
    logic         g_rd_rdy, g_wr_rdy, g_ret_valid, g_ret_last;
    logic [31:0]  g_ret_data;

    always #5 clk = ~clk;

    cache_mem_responder #(.LOG_W(2), .MEM_AW(12), .RET_GAP(0)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_size(wr_size), .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    cache_mem_responder #(.LOG_W(2), .MEM_AW(12), .RET_GAP(2)) dut_gap (
        .clk(clk), .reset(g_reset),
        .rd_req(g_rd_req), .rd_type(g_rd_type), .rd_addr(g_rd_addr), .rd_rdy(g_rd_rdy),
        .ret_valid(g_ret_valid), .ret_last(g_ret_last), .ret_data(g_ret_data),
        .wr_req(g_wr_req), .wr_type(g_wr_type), .wr_addr(g_wr_addr), .wr_wstrb(g_wr_wstrb),
        .wr_size(g_wr_size), .wr_data(g_wr_data), .wr_rdy(g_wr_rdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                            input logic [3:0] s, input logic [127:0] d);
        wr_type  = t;
        wr_addr  = a;
        wr_wstrb = s;
        wr_data  = d;
        wr_req   = 1'b1;
        #1;
        check("wr_rdy_idle", {31'd0, wr_rdy}, 32'd1);
        step();
        wr_req = 1'b0;
        check("wr_rdy_in_write", {31'd0, wr_rdy}, 32'd0);
        check("rd_rdy_in_write", {31'd0, rd_rdy}, 32'd0);
        step();
    endtask

    task automatic do_read(input logic [2:0] t, input logic [31:0] a);
        rd_type = t;
        rd_addr = a;
        rd_req  = 1'b1;
        #1;
        check("rd_rdy_idle", {31'd0, rd_rdy}, 32'd1);
        step();
        rd_req = 1'b0;
    endtask

    // Called in cycle T+1 of an accepted read; walks n beats then the return to idle.
    task automatic check_burst(input string tag, input int n, input logic [127:0] words);
        logic [127:0] w;
        w = words;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, {31'd0, ret_valid}, 32'd1);
            check({tag, "_data"}, ret_data, w[32*i +: 32]);
            check({tag, "_last"}, {31'd0, ret_last}, (i == n - 1) ? 32'd1 : 32'd0);
            check({tag, "_rdy_busy"}, {31'd0, rd_rdy}, 32'd0);
            step();
        end
        check({tag, "_valid_end"}, {31'd0, ret_valid}, 32'd0);
        check({tag, "_rdy_end"}, {31'd0, rd_rdy}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [127:0] line_a, line_b, line_g;
        logic [3:0]   exp_pat;
        line_a = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        line_b = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        line_g = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};

        reset = 1'b1; rd_req = 1'b1; rd_type = ACCESS_SZ_LINE; rd_addr = 32'h0;
        wr_req = 1'b0; wr_type = ACCESS_SZ_WORD; wr_addr = 32'h0; wr_wstrb = 4'h0;
        wr_size = 3'b010; wr_data = '0;
        g_reset = 1'b1; g_rd_req = 1'b0; g_rd_type = ACCESS_SZ_LINE; g_rd_addr = 32'h0;
        g_wr_req = 1'b0; g_wr_type = ACCESS_SZ_LINE; g_wr_addr = 32'h0; g_wr_wstrb = 4'h0;
        g_wr_size = 3'b010; g_wr_data = '0;

        // Reset held three cycles with a read request pending
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_rd_rdy", {31'd0, rd_rdy}, 32'd0);
            check("reset_ret_valid", {31'd0, ret_valid}, 32'd0);
            check("reset_ret_data", ret_data, 32'd0);
        end
        reset = 1'b0;
        rd_req = 1'b0;
        #1;
        check("post_reset_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        check("post_reset_ret_last", {31'd0, ret_last}, 32'd0);
        step();

        // Line write then line read from an unaligned address in the same line
        do_write(ACCESS_SZ_LINE, 32'h0000_0100, 4'h0, line_a);
        do_read(ACCESS_SZ_LINE, 32'h0000_010C);
        check_burst("line_rd", 4, line_a);

        // Address bits above the memory size alias back onto the same line
        do_read(ACCESS_SZ_LINE, 32'h0000_4100);
        check_burst("wrap_rd", 4, line_a);

        // Masked word writes over a zeroed line
        do_write(ACCESS_SZ_LINE, 32'h0000_0200, 4'h0, '0);
        do_write(ACCESS_SZ_WORD, 32'h0000_0200, 4'b0101, {96'd0, 32'hAABB_CCDD});
        do_write(ACCESS_SZ_WORD, 32'h0000_0208, 4'b1111, {96'd0, 32'h1234_5678});
        do_read(ACCESS_SZ_WORD, 32'h0000_0200);
        check_burst("word_rd", 1, {96'd0, 32'h00BB_00DD});
        do_read(ACCESS_SZ_BYTE, 32'h0000_020A);
        check_burst("byte_rd", 1, {96'd0, 32'h1234_5678});
        do_read(ACCESS_SZ_HALF, 32'h0000_0206);
        check_burst("half_rd", 1, 128'd0);

        // Simultaneous read and write: the write wins, the read waits
        wr_type = ACCESS_SZ_LINE; wr_addr = 32'h0000_0300; wr_data = line_b; wr_req = 1'b1;
        rd_type = ACCESS_SZ_LINE; rd_addr = 32'h0000_0300; rd_req = 1'b1;
        #1;
        check("both_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        check("both_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        step();
        wr_req = 1'b0;
        check("both_write_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        check("both_write_valid", {31'd0, ret_valid}, 32'd0);
        step();
        check("both_idle_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        check("both_idle_valid", {31'd0, ret_valid}, 32'd0);
        step();
        rd_req = 1'b0;
        check_burst("raw_rd", 4, line_b);

        // Reset during beat 1 abandons the burst
        do_read(ACCESS_SZ_LINE, 32'h0000_0100);
        check("abort_beat0", ret_data, 32'h0000_0011);
        step();
        check("abort_beat1", ret_data, 32'h0000_0022);
        reset = 1'b1;
        step();
        check("abort_valid", {31'd0, ret_valid}, 32'd0);
        check("abort_last", {31'd0, ret_last}, 32'd0);
        check("abort_data", ret_data, 32'd0);
        check("abort_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        reset = 1'b0;
        step();
        check("abort_after_valid", {31'd0, ret_valid}, 32'd0);
        step();
        check("abort_after_valid2", {31'd0, ret_valid}, 32'd0);
        do_read(ACCESS_SZ_LINE, 32'h0000_0304);
        check_burst("after_abort_rd", 4, line_b);

        // RET_GAP=2 instance: beats separated by two idle cycles
        g_reset = 1'b0;
        step();
        g_wr_addr = 32'h0000_0040; g_wr_data = line_g; g_wr_req = 1'b1;
        step();
        g_wr_req = 1'b0;
        step();
        g_rd_addr = 32'h0000_0048; g_rd_req = 1'b1;
        #1;
        check("gap_rd_rdy_idle", {31'd0, g_rd_rdy}, 32'd1);
        step();
        g_rd_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("gap_valid", {31'd0, g_ret_valid}, (i % 3 == 0) ? 32'd1 : 32'd0);
            check("gap_last", {31'd0, g_ret_last}, (i == 9) ? 32'd1 : 32'd0);
            check("gap_rd_rdy_busy", {31'd0, g_rd_rdy}, 32'd0);
            if (i % 3 == 0) begin
                check("gap_data", g_ret_data, line_g[32*(i/3) +: 32]);
            end
            step();
        end
        exp_pat = 4'b0000;
        check("gap_valid_end", {31'd0, g_ret_valid}, {28'd0, exp_pat});
        check("gap_rd_rdy_end", {31'd0, g_rd_rdy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
